// File: rtl/cache_arbiter.sv
// Arbitrates a single RAM port between icache fills and dcache reads/writes.
// Optional round-robin arbitration on simultaneous requests: define ARB_RR_EN.
module cache_arbiter #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache side
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'b00,
    RAM_BUSY   = 2'b01,
    RAM_ACCESS = 2'b10,
    RAM_ERROR  = 2'b11
  } ram_state_t;

  state_t state, nextState;
  logic   dReq;
  logic   bothToI;

  assign dReq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

`ifdef ARB_RR_EN
  // High when the dcache completed the most recent transfer; reset favours dcache next.
  logic lastGrantD;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lastGrantD <= 1'b0;
    end else if (ram_state_t'(ramstate) == RAM_ACCESS) begin
      if (state == DSERV && dReq)
        lastGrantD <= 1'b1;
      else if (state == ISERV && iREN)
        lastGrantD <= 1'b0;
    end
  end

  assign bothToI = lastGrantD;
`else
  assign bothToI = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= nextState;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;

    unique case (state)
      IDLE: begin
        if (dReq && iREN)
          nextState = bothToI ? ISERV : DSERV;
        else if (dReq)
          nextState = DSERV;
        else if (iREN)
          nextState = ISERV;
      end

      DSERV: begin
        if (!dReq) begin
          nextState = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ram_state_t'(ramstate) == RAM_ACCESS) begin
            dwait     = 1'b0;
            nextState = IDLE;
          end else if (ram_state_t'(ramstate) == RAM_ERROR) begin
            nextState = IDLE;
          end
        end
      end

      ISERV: begin
        if (!iREN) begin
          nextState = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ram_state_t'(ramstate) == RAM_ACCESS) begin
            iwait     = 1'b0;
            nextState = IDLE;
          end else if (ram_state_t'(ramstate) == RAM_ERROR) begin
            nextState = IDLE;
          end
        end
      end

      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level ownership model.
module tb_cache_arbiter;
  localparam int W = 32;
  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [W-1:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]   ramstate = FREE;
  logic         iwait, dwait, ramREN, ramWEN;
  logic [W-1:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int failures = 0;

  cache_arbiter #(.WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which side currently owns the RAM, and who completed last.
  typedef enum {NONE, SIDE_D, SIDE_I} owner_t;
  owner_t owner = NONE;
  bit     lastD = 1'b0;

  logic         eREN, eWEN, eIwait, eDwait, checkBus;
  logic [W-1:0] eAddr, eStore;
  owner_t       nextOwner;

  always @(negedge CLK) begin
    eREN = 0; eWEN = 0; eIwait = 1; eDwait = 1;
    eAddr = '0; eStore = '0; checkBus = 0;
    nextOwner = owner;
    if (!nRST) begin
      checkBus  = 1;
      nextOwner = NONE;
      lastD     = 1'b0;
    end else begin
      case (owner)
        NONE: begin
          if ((dREN || dWEN) && iREN) begin
`ifdef ARB_RR_EN
            nextOwner = lastD ? SIDE_I : SIDE_D;
`else
            nextOwner = SIDE_D;
`endif
          end else if (dREN || dWEN) nextOwner = SIDE_D;
          else if (iREN) nextOwner = SIDE_I;
        end
        SIDE_D: begin
          if (!(dREN || dWEN)) nextOwner = NONE;
          else begin
            eWEN = dWEN; eREN = dREN && !dWEN;
            eAddr = daddr; eStore = dstore; checkBus = 1;
            if (ramstate == ACCESS) begin eDwait = 0; nextOwner = NONE; lastD = 1'b1; end
            else if (ramstate == ERROR) nextOwner = NONE;
          end
        end
        SIDE_I: begin
          if (!iREN) nextOwner = NONE;
          else begin
            eREN = 1; eAddr = iaddr; eStore = '0; checkBus = 1;
            if (ramstate == ACCESS) begin eIwait = 0; nextOwner = NONE; lastD = 1'b0; end
            else if (ramstate == ERROR) nextOwner = NONE;
          end
        end
        default: nextOwner = NONE;
      endcase
    end
    check("m_ramREN", W'(ramREN), W'(eREN));
    check("m_ramWEN", W'(ramWEN), W'(eWEN));
    check("m_iwait", W'(iwait), W'(eIwait));
    check("m_dwait", W'(dwait), W'(eDwait));
    check("m_iload", iload, ramload);
    check("m_dload", dload, ramload);
    if (checkBus) begin
      check("m_ramaddr", ramaddr, eAddr);
      check("m_ramstore", ramstore, eStore);
    end
    owner = nextOwner;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramstate = FREE;
  endtask

  task automatic doReset();
    nRST = 0;
    clearInputs();
    #1;
    check("rst_ramREN", W'(ramREN), 0);
    check("rst_ramWEN", W'(ramWEN), 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait", W'(iwait), 1);
    check("rst_dwait", W'(dwait), 1);
    repeat (2) tick();
    nRST = 1;
  endtask

  initial begin
    doReset();

    // Data read acked on the first serve cycle.
    dREN = 1; daddr = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #1;
    check("rd_idle_ramREN", W'(ramREN), 0);
    check("rd_idle_dwait", W'(dwait), 1);
    tick();
    check("rd_ramREN", W'(ramREN), 1);
    check("rd_ramaddr", ramaddr, 32'h100);
    check("rd_dwait", W'(dwait), 0);
    check("rd_dload", dload, 32'hDEADBEEF);
    tick();
    dREN = 0;
    #1;
    check("rd_after_ramREN", W'(ramREN), 0);
    check("rd_after_dwait", W'(dwait), 1);

    // Write wins over a simultaneous read.
    tick();
    dREN = 1; dWEN = 1; daddr = 32'h3100; dstore = 32'h5; ramstate = ACCESS;
    tick();
    check("wr_ramWEN", W'(ramWEN), 1);
    check("wr_ramREN", W'(ramREN), 0);
    check("wr_ramstore", ramstore, 32'h5);
    check("wr_ramaddr", ramaddr, 32'h3100);
    check("wr_dwait", W'(dwait), 0);
    tick();
    dREN = 0; dWEN = 0;
    #1;
    check("wr_after_ramWEN", W'(ramWEN), 0);

    // Instruction fill stalled by a busy RAM.
    tick();
    iREN = 1; iaddr = 32'h40; ramstate = BUSY;
    #1;
    check("if_idle_iwait", W'(iwait), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("if_busy_ramREN", W'(ramREN), 1);
      check("if_busy_ramaddr", ramaddr, 32'h40);
      check("if_busy_iwait", W'(iwait), 1);
    end
    tick();
    ramstate = ACCESS;
    #1;
    check("if_ack_iwait", W'(iwait), 0);
    check("if_ack_ramREN", W'(ramREN), 1);
    tick();
    iREN = 0;
    #1;
    check("if_after_ramREN", W'(ramREN), 0);
    check("if_after_iwait", W'(iwait), 1);

    // Both sides held with RAM always ready: arbitration pattern.
    tick();
    doReset();
    iREN = 1; dREN = 1; iaddr = 32'h80; daddr = 32'h90; ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      logic expD, expI;
      tick();
      expD = 0; expI = 0;
      if (k % 2 == 0) begin
`ifdef ARB_RR_EN
        expD = ((k / 2) % 2 == 0);
        expI = !expD;
`else
        expD = 1;
`endif
      end
      check("both_dwait", W'(dwait), W'(!expD));
      check("both_iwait", W'(iwait), W'(!expI));
    end
    clearInputs();

    // RAM error: no ack, back to idle, request re-granted.
    tick();
    tick();
    dREN = 1; daddr = 32'h200; ramstate = ERROR;
    tick();
    check("err_ramREN", W'(ramREN), 1);
    check("err_dwait", W'(dwait), 1);
    tick();
    ramstate = BUSY;
    #1;
    check("err_idle_ramREN", W'(ramREN), 0);
    tick();
    check("err_regrant_ramREN", W'(ramREN), 1);
    check("err_regrant_ramaddr", ramaddr, 32'h200);
    // Asynchronous reset in the middle of the data transfer.
    #2;
    nRST = 0;
    #1;
    check("arst_ramREN", W'(ramREN), 0);
    check("arst_dwait", W'(dwait), 1);
    check("arst_ramaddr", ramaddr, 0);
    tick();
    dREN = 0; nRST = 1;
    #1;
    check("arst_after_ramREN", W'(ramREN), 0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 2000; n++) begin
      tick();
      nRST     = ($urandom_range(0, 59) != 0);
      iREN     = ($urandom_range(0, 2) != 0);
      dREN     = ($urandom_range(0, 2) != 0);
      dWEN     = ($urandom_range(0, 3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramload  = $urandom;
      ramstate = 2'($urandom_range(0, 3));
    end

    tick();
    clearInputs();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
